tdm_demux_1to4: RTL and testbench



---
 rtl/tdm_demux_pkg.sv | 11 +
 rtl/onehot_decoder_2to4.sv | 13 +
 rtl/tdm_demux_1to4.sv | 122 ++++++++++++
 tb/tb_tdm_demux_1to4.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared constants and FSM state type for the 1:4 TDM demultiplexer
package tdm_demux_pkg;
  localparam int NUM_CH      = 4;
  localparam int SLOT_W      = 2;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;
endpackage

// File: rtl/onehot_decoder_2to4.sv
// rtl/onehot_decoder_2to4.sv - combinational 2-to-4 one-hot decoder with enable
module onehot_decoder_2to4
  import tdm_demux_pkg::*;
(
  input  logic [SLOT_W-1:0] sel,
  input  logic              en,
  output logic [NUM_CH-1:0] onehot
);
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end
endmodule

// File: rtl/tdm_demux_1to4.sv
// rtl/tdm_demux_1to4.sv - framed 1:4 TDM demultiplexer into four channel hold registers
// Optional frame counter output enabled by `define TDM_DEMUX_FRAME_CNT_EN.
module tdm_demux_1to4
  import tdm_demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [W-1:0]           din,
  input  logic                   din_valid,
  input  logic                   frame_sync,
  output logic [NUM_CH*W-1:0]    dout,
  output logic [NUM_CH-1:0]      dout_valid,
  output logic                   frame_done,
  output logic                   sync_err,
`ifdef TDM_DEMUX_FRAME_CNT_EN
  output logic [FRAME_CNT_W-1:0] frame_cnt,
`endif
  output logic                   locked
);
  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [NUM_CH*W-1:0] dout_q, dout_d;
  logic [NUM_CH-1:0]   dout_valid_q;
  logic                frame_done_q, frame_done_d;
  logic                sync_err_q, sync_err_d;
  logic                locked_q;

  logic                beat;
  logic                wr_en;
  logic [SLOT_W-1:0]   wr_sel;
  logic [NUM_CH-1:0]   wr_strobe;

  assign beat = en & din_valid;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    wr_en        = 1'b0;
    wr_sel       = slot_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    if (beat) begin
      if (frame_sync) begin
        // Any sync beat (re)starts the frame at ch0; a sync mid-frame is an error.
        wr_en      = 1'b1;
        wr_sel     = '0;
        slot_d     = SLOT_W'(1);
        state_d    = RUN;
        sync_err_d = (state_q == RUN) && (slot_q != '0);
      end else if (state_q == RUN) begin
        if (slot_q == '0) begin
          sync_err_d = 1'b1;
          state_d    = IDLE;
          slot_d     = '0;
        end else begin
          wr_en        = 1'b1;
          slot_d       = slot_q + SLOT_W'(1);
          frame_done_d = (slot_q == SLOT_W'(NUM_CH - 1));
        end
      end
    end
  end

  onehot_decoder_2to4 u_dec (
    .sel    (wr_sel),
    .en     (wr_en),
    .onehot (wr_strobe)
  );

  always_comb begin
    dout_d = dout_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_strobe[k]) dout_d[k*W +: W] = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      dout_q       <= dout_d;
      dout_valid_q <= wr_strobe;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      locked_q     <= (state_d == RUN);
    end
  end

`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (sync_err_d)        frame_cnt_d = '0;
    else if (frame_done_d) frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = locked_q;
endmodule

// File: tb/tb_tdm_demux_1to4.sv
// tb/tb_tdm_demux_1to4.sv - directed and randomized checks of tdm_demux_1to4 against a frame model
module tb_tdm_demux_1to4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          frame_sync;
  logic [4*W-1:0] dout;
  logic [3:0]    dout_valid;
  logic          frame_done;
  logic          sync_err;
  logic          locked;
`ifdef TDM_DEMUX_FRAME_CNT_EN
  logic [7:0]    frame_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Frame-level reference: lock flag, next expected slot, channel contents.
  bit       m_locked;
  int       m_pos;
  bit [7:0] m_ch [4];
  int       m_cnt;
  bit [3:0] e_valid;
  bit       e_done;
  bit       e_err;

  tdm_demux_1to4 #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
`ifdef TDM_DEMUX_FRAME_CNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_pos    = 0;
    m_cnt    = 0;
    for (int k = 0; k < 4; k++) m_ch[k] = 8'h00;
    e_valid = '0;
    e_done  = 0;
    e_err   = 0;
  endtask

  task automatic model_step(input bit e, input bit v, input bit fs, input bit [7:0] d);
    e_valid = '0;
    e_done  = 0;
    e_err   = 0;
    if (e && v) begin
      if (fs) begin
        e_err    = m_locked && (m_pos != 0);
        m_ch[0]  = d;
        e_valid  = 4'b0001;
        m_pos    = 1;
        m_locked = 1;
      end else if (m_locked) begin
        if (m_pos == 0) begin
          e_err    = 1;
          m_locked = 0;
        end else begin
          m_ch[m_pos] = d;
          e_valid     = 4'(1 << m_pos);
          e_done      = (m_pos == 3);
          m_pos       = (m_pos + 1) % 4;
        end
      end
    end
    if (e_err) m_cnt = 0;
    else if (e_done) m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic check_all();
    chk("dout", dout, {m_ch[3], m_ch[2], m_ch[1], m_ch[0]});
    chk("dout_valid", 32'(dout_valid), 32'(e_valid));
    chk("frame_done", 32'(frame_done), 32'(e_done));
    chk("sync_err", 32'(sync_err), 32'(e_err));
    chk("locked", 32'(locked), 32'(m_locked));
`ifdef TDM_DEMUX_FRAME_CNT_EN
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
`endif
  endtask

  task automatic step(input bit e, input bit v, input bit fs, input bit [7:0] d);
    @(negedge clk);
    en = e; din_valid = v; frame_sync = fs; din = d;
    model_step(e, v, fs, d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic frame(input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2, input bit [7:0] b3);
    step(1, 1, 1, b0);
    step(1, 1, 0, b1);
    step(1, 1, 0, b2);
    step(1, 1, 0, b3);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 0; din_valid = 0; frame_sync = 0; din = '0;
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    bit e, v, fs;
    rst_n = 0; en = 0; din_valid = 0; frame_sync = 0; din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    chk("reset_dout", dout, 32'h0);
    rst_n = 1;

    // Clean frame and its exact packing.
    frame(8'h11, 8'h22, 8'h33, 8'h44);
    chk("frame1_dout", dout, 32'h44332211);
    chk("frame1_locked", 32'(locked), 32'h1);

    // Back-to-back frames.
    frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    chk("frame2_dout", dout, 32'hA3A2A1A0);

    // Early sync on the third beat.
    step(1, 1, 1, 8'h66);
    step(1, 1, 0, 8'h77);
    step(1, 1, 1, 8'h55);
    chk("early_err", 32'(sync_err), 32'h1);
    chk("early_valid", 32'(dout_valid), 32'h1);
    step(1, 1, 0, 8'h88);
    chk("early_next_ch1", 32'(dout_valid), 32'h2);
    step(1, 1, 0, 8'h89);
    step(1, 1, 0, 8'h8A);

    // Missing sync after a full frame, then ignored beats until resync.
    step(1, 1, 0, 8'h99);
    chk("missing_locked", 32'(locked), 32'h0);
    step(1, 1, 0, 8'h9A);
    step(1, 1, 0, 8'h9B);
    frame(8'h01, 8'h02, 8'h03, 8'h04);

    // Enable low mid-frame with din_valid toggling.
    step(1, 1, 1, 8'hC0);
    step(1, 1, 0, 8'hC1);
    step(0, 1, 0, 8'hE0);
    step(0, 0, 1, 8'hE1);
    step(0, 1, 1, 8'hE2);
    step(1, 1, 0, 8'hC2);
    chk("resume_slot2", 32'(dout_valid), 32'h4);
    step(1, 1, 0, 8'hC3);

    // Asynchronous reset mid-frame after slot 2.
    step(1, 1, 1, 8'hD0);
    step(1, 1, 0, 8'hD1);
    step(1, 1, 0, 8'hD2);
    @(negedge clk);
    en = 0; din_valid = 0; frame_sync = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1;

    // Three clean frames from reset.
    frame(8'h10, 8'h20, 8'h30, 8'h40);
    frame(8'h50, 8'h60, 8'h70, 8'h80);
    frame(8'h90, 8'hB0, 8'hC0, 8'hF0);
`ifdef TDM_DEMUX_FRAME_CNT_EN
    chk("frame_cnt_3", 32'(frame_cnt), 32'h3);
`endif

    // Randomized traffic, syncs biased toward frame boundaries.
    for (int i = 0; i < 600; i++) begin
      e  = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 4) != 0);
      if (m_pos == 0) fs = ($urandom_range(0, 9) < 8);
      else            fs = ($urandom_range(0, 19) == 0);
      step(e, v, fs, 8'($urandom));
      if (i == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
